// File: rtl/fpu_issue_queue_if.sv
// Request and result handshake channels of the FP/logic ALU issue queue.
// The slave side belongs to the queue, the master side to whatever feeds and drains it.
interface fpu_issue_queue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic             out_exc;
    logic             out_ovf;
    logic             out_unf;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_exc, out_ovf, out_unf, out_tag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_exc, out_ovf, out_unf, out_tag
    );
endinterface

// File: rtl/fpu_issue_queue.sv
// In-order issue queue in front of the combinational 64-bit FP/logic ALU: request FIFO -> issue slot -> result register.
// Optional feature macro STICKY_FLAGS_EN adds accumulated {unf,ovf,exc} flags with a synchronous clear.
module fpu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_issue_queue_if.slave      bus,
    output logic                  alu_enable,
    output logic [3:0]            alu_op,
    output logic [63:0]           alu_a,
    output logic [63:0]           alu_b,
    input  logic [63:0]           alu_result,
    input  logic                  alu_exc,
    input  logic                  alu_ovf,
    input  logic                  alu_unf
`ifdef STICKY_FLAGS_EN
    ,
    input  logic                  flag_clear,
    output logic [2:0]            sticky_flags
`endif
);
    localparam int DATA_W = 64;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef enum logic {IDLE, EXEC} state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op != 4'd0) && (op <= 4'd11);
    endfunction

    // ALU flags are only meaningful for the arithmetic ops; returned as {unf, ovf, exc}.
    function automatic logic [2:0] mask_flags(input logic [3:0] op, input logic exc,
                                              input logic ovf, input logic unf);
        logic [2:0] f;
        f = 3'b000;
        if (!op_legal(op))
            f = 3'b001;
        else if (op <= 4'd3)
            f = {unf, ovf, exc};
        else if (op == 4'd4)
            f = {2'b00, exc};
        return f;
    endfunction

    req_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push, pop, capture, advance;
    state_t            state_q, state_d;

    logic [3:0]        op_p1;
    logic [DATA_W-1:0] a_p1, b_p1;
    logic [TAG_W-1:0]  tag_p1;

    logic              vld_p2;
    logic [DATA_W-1:0] result_p2;
    logic [2:0]        flags_p2;
    logic [TAG_W-1:0]  tag_p2;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = bus.in_valid && bus.in_ready;
    assign advance = !vld_p2 || bus.out_ready;

    assign bus.in_ready = !full && !rst;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (advance) begin
                    capture = 1'b1;
                    if (!empty)
                        pop = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Stage p0: request FIFO
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stage p1: issue slot, drives the ALU and holds through output stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_p1  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
            tag_p1 <= '0;
        end else if (pop) begin
            op_p1  <= fifo_mem[rd_ptr].op;
            a_p1   <= fifo_mem[rd_ptr].a;
            b_p1   <= fifo_mem[rd_ptr].b;
            tag_p1 <= fifo_mem[rd_ptr].tag;
        end
    end

    assign alu_enable = (state_q == EXEC) && op_legal(op_p1);
    assign alu_op     = op_p1;
    assign alu_a      = a_p1;
    assign alu_b      = b_p1;

    // Stage p2: result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            flags_p2  <= '0;
            tag_p2    <= '0;
        end else if (capture) begin
            vld_p2    <= 1'b1;
            result_p2 <= op_legal(op_p1) ? alu_result : '0;
            flags_p2  <= mask_flags(op_p1, alu_exc, alu_ovf, alu_unf);
            tag_p2    <= tag_p1;
        end else if (bus.out_ready) begin
            vld_p2    <= 1'b0;
        end
    end

    assign bus.out_valid  = vld_p2;
    assign bus.out_result = result_p2;
    assign bus.out_exc    = flags_p2[0];
    assign bus.out_ovf    = flags_p2[1];
    assign bus.out_unf    = flags_p2[2];
    assign bus.out_tag    = tag_p2;

`ifdef STICKY_FLAGS_EN
    // A flag delivered on the same edge as a clear survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky_flags <= 3'b000;
        else if (vld_p2 && bus.out_ready)
            sticky_flags <= (flag_clear ? 3'b000 : sticky_flags) | flags_p2;
        else if (flag_clear)
            sticky_flags <= 3'b000;
    end
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue: table of single-op vectors plus stall, flag-masking and reset sequences.
module tb_fpu_issue_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_enable;
    logic [3:0]  alu_op;
    logic [63:0] alu_a, alu_b, alu_result;
    logic        alu_exc, alu_ovf, alu_unf;
    logic        stuck;
`ifdef STICKY_FLAGS_EN
    logic        flag_clear;
    logic [2:0]  sticky_flags;
`endif

    fpu_issue_queue_if #(.TAG_W(4)) bus ();

    fpu_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_enable (alu_enable),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_exc    (alu_exc),
        .alu_ovf    (alu_ovf),
        .alu_unf    (alu_unf)
`ifdef STICKY_FLAGS_EN
        ,
        .flag_clear   (flag_clear),
        .sticky_flags (sticky_flags)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational ALU; "stuck" forces all flags high.
    always_comb begin
        alu_result = 64'h0;
        case (alu_op)
            4'd1:  alu_result = $realtobits($bitstoreal(alu_a) + $bitstoreal(alu_b));
            4'd2:  alu_result = $realtobits($bitstoreal(alu_a) - $bitstoreal(alu_b));
            4'd3:  alu_result = $realtobits($bitstoreal(alu_a) * $bitstoreal(alu_b));
            4'd4:  alu_result = (alu_b == 64'h0) ? {alu_a[63], 11'h7FF, 52'h0}
                                                 : $realtobits($bitstoreal(alu_a) / $bitstoreal(alu_b));
            4'd5:  alu_result = alu_a & alu_b;
            4'd6:  alu_result = alu_a | alu_b;
            4'd7:  alu_result = alu_a ^ alu_b;
            4'd8:  alu_result = ~alu_a;
            4'd9:  alu_result = alu_a << alu_b[5:0];
            4'd10: alu_result = alu_a >> alu_b[5:0];
            4'd11: alu_result = alu_a;
            default: alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
        alu_ovf = (alu_op >= 4'd1) && (alu_op <= 4'd3) && (alu_result[62:52] == 11'h7FF);
        alu_exc = alu_ovf || ((alu_op == 4'd4) && (alu_b == 64'h0));
        alu_unf = 1'b0;
        if (stuck) begin
            alu_exc = 1'b1;
            alu_ovf = 1'b1;
            alu_unf = 1'b1;
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  tag;
        logic [63:0] res;
        logic [2:0]  flg;   // {unf, ovf, exc}
    } vec_t;

    vec_t vecs [13];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic en_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] tag);
        int k;
        @(negedge clk);
        bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check("push_timeout", {63'h0, bus.in_ready}, 64'h1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        en_seen = 1'b0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (alu_enable) en_seen = 1'b1;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) check("out_timeout", {63'h0, bus.out_valid}, 64'h1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int cyc;
        push(v.op, v.a, v.b, v.tag);
        wait_out(cyc);
        check({name, "_result"}, bus.out_result, v.res);
        check({name, "_tag"}, {60'h0, bus.out_tag}, {60'h0, v.tag});
        check({name, "_flags"}, {61'h0, bus.out_unf, bus.out_ovf, bus.out_exc}, {61'h0, v.flg});
    endtask

    initial begin
        int   cyc, acc;
        logic rdy7, seen;

        vecs[0]  = '{4'd1,  64'h3FF0000000000000, 64'h4000000000000000, 4'd3,  64'h4008000000000000, 3'b000};
        vecs[1]  = '{4'd2,  64'h4008000000000000, 64'h3FF0000000000000, 4'd1,  64'h4000000000000000, 3'b000};
        vecs[2]  = '{4'd3,  64'h4000000000000000, 64'h4008000000000000, 4'd2,  64'h4018000000000000, 3'b000};
        vecs[3]  = '{4'd4,  64'h3FF0000000000000, 64'h0,                4'd4,  64'h7FF0000000000000, 3'b001};
        vecs[4]  = '{4'd3,  64'h7FE0000000000000, 64'h4000000000000000, 4'd5,  64'h7FF0000000000000, 3'b011};
        vecs[5]  = '{4'd5,  64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 4'd6,  64'h0F000F000F000F00, 3'b000};
        vecs[6]  = '{4'd6,  64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 4'd7,  64'hFF0FFF0FFF0FFF0F, 3'b000};
        vecs[7]  = '{4'd7,  64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 4'd8,  64'hF00FF00FF00FF00F, 3'b000};
        vecs[8]  = '{4'd8,  64'hFF00FF00FF00FF00, 64'h0,                4'd9,  64'h00FF00FF00FF00FF, 3'b000};
        vecs[9]  = '{4'd9,  64'h1,                64'h4,                4'd10, 64'h10,               3'b000};
        vecs[10] = '{4'd10, 64'h8000000000000000, 64'd63,               4'd11, 64'h1,                3'b000};
        vecs[11] = '{4'd0,  64'h1234,             64'h5678,             4'd12, 64'h0,                3'b001};
        vecs[12] = '{4'd13, 64'h1234,             64'h5678,             4'd13, 64'h0,                3'b001};

        rst = 1'b1;
        stuck = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_a = 64'h0; bus.in_b = 64'h0; bus.in_tag = 4'd0;
        bus.out_ready = 1'b1;
`ifdef STICKY_FLAGS_EN
        flag_clear = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
        check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        check("rst_alu_enable", {63'h0, alu_enable}, 64'h0);
        check("rst_out_result", bus.out_result, 64'h0);
        check("rst_alu_a", alu_a, 64'h0);
        @(negedge clk) rst = 1'b0;
        #1 check("in_ready_after_rst", {63'h0, bus.in_ready}, 64'h1);

        // First vector also measures accept-to-valid latency.
        push(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].tag);
        wait_out(cyc);
        check("latency", 64'(cyc), 64'd2);
        check("v0_result", bus.out_result, vecs[0].res);
        check("v0_tag", {60'h0, bus.out_tag}, {60'h0, vecs[0].tag});
        check("v0_flags", {61'h0, bus.out_unf, bus.out_ovf, bus.out_exc}, {61'h0, vecs[0].flg});

        for (int i = 1; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            if (vecs[i].op == 4'd0 || vecs[i].op > 4'd11)
                check($sformatf("v%0d_alu_enable_seen", i), {63'h0, en_seen}, 64'h0);
        end

        // Flags forced high by the ALU must be masked by op class.
        stuck = 1'b1;
        run_vec('{4'd3, 64'h7FE0000000000000, 64'h4000000000000000, 4'd1, 64'h7FF0000000000000, 3'b111}, "stuck_mul");
        run_vec('{4'd5, 64'hFFFF, 64'h00F0, 4'd2, 64'h00F0, 3'b000}, "stuck_and");
        run_vec('{4'd4, 64'h3FF0000000000000, 64'h0, 4'd3, 64'h7FF0000000000000, 3'b001}, "stuck_div");
        stuck = 1'b0;
        @(posedge clk);

        // Back-pressure: DEPTH+2 requests fit, then in_ready drops.
        @(negedge clk) bus.out_ready = 1'b0;
        acc = 0;
        rdy7 = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            bus.in_op = 4'd5; bus.in_a = 64'h100 + 64'(t); bus.in_b = '1; bus.in_tag = 4'(t);
            bus.in_valid = 1'b1;
            if (bus.in_ready) acc++;
            if (t == 6) rdy7 = bus.in_ready;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
        check("stall_accepted", 64'(acc), 64'd6);
        check("stall_in_ready_7th", {63'h0, rdy7}, 64'h0);
        check("stall_out_tag", {60'h0, bus.out_tag}, 64'h0);
        check("stall_alu_a", alu_a, 64'h101);
        check("stall_alu_enable", {63'h0, alu_enable}, 64'h1);
        repeat (3) @(posedge clk);
        #1;
        check("stall_alu_a_held", alu_a, 64'h101);
        check("stall_alu_op_held", {60'h0, alu_op}, 64'd5);
        @(negedge clk) bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("drain%0d_valid", k), {63'h0, bus.out_valid}, 64'h1);
            check($sformatf("drain%0d_tag", k), {60'h0, bus.out_tag}, 64'(k));
            check($sformatf("drain%0d_result", k), bus.out_result, 64'h100 + 64'(k));
            @(posedge clk);
            #1;
        end
        check("drain_empty", {63'h0, bus.out_valid}, 64'h0);

        // Reset with work queued: nothing from before the reset may emerge.
        @(negedge clk) bus.out_ready = 1'b0;
        for (int t = 0; t < 5; t++) push(4'd6, 64'(t), 64'h0, 4'(t + 8));
        @(negedge clk) rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        check("midrst_in_ready", {63'h0, bus.in_ready}, 64'h0);
        @(negedge clk) begin
            rst = 1'b0;
            bus.out_ready = 1'b1;
        end
        #1 check("postrst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || alu_enable) seen = 1'b1;
        end
        check("postrst_no_stale", {63'h0, seen}, 64'h0);

`ifdef STICKY_FLAGS_EN
        check("sticky_after_rst", {61'h0, sticky_flags}, 64'h0);
        run_vec(vecs[3], "sticky_div");
        @(posedge clk);
        #1 check("sticky_set", {61'h0, sticky_flags}, 64'h1);
        @(negedge clk) flag_clear = 1'b1;
        @(posedge clk);
        #1 flag_clear = 1'b0;
        check("sticky_cleared", {61'h0, sticky_flags}, 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
